player_motion_ctrl: RTL and testbench

PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

---
 rtl/vga_pkg.sv | 26 ++
 rtl/rect_overlap.sv | 38 +++
 rtl/player_motion_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA player-motion block.
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   TICK_V_DEF / TICK_H_DEF : raster position of the once-per-frame update tick
//   STEP_DEF / SQ_LEN_DEF   : default motion step and square edge offset
//   motion_state_t          : update FSM state encoding
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int TICK_V_DEF = 481;
    localparam int TICK_H_DEF = 0;
    localparam int STEP_DEF   = 2;
    localparam int SQ_LEN_DEF = 20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        MOVE_X = 3'd2,
        MOVE_Y = 3'd3,
        DONE   = 3'd4
    } motion_state_t;

endpackage

// File: rtl/rect_overlap.sv
// -----------------------------------------------------------------------------
// rect_overlap
// Combinational test of whether a square at (left, top) with edge offset
// `length` touches an inclusive wall rectangle. Inclusive on every side so the
// result agrees with what the renderer draws.
// Ports:
//   left, top        : square top-left corner
//   length           : edge offset (right = left+length, bottom = top+length)
//   wall_h_min/max   : wall horizontal extent, inclusive
//   wall_v_min/max   : wall vertical extent, inclusive
//   hit              : 1 when the square and the wall overlap
// -----------------------------------------------------------------------------
module rect_overlap
    import vga_pkg::*;
(
    input  logic [10:0] left,
    input  logic [10:0] top,
    input  logic [10:0] length,
    input  logic [10:0] wall_h_min,
    input  logic [10:0] wall_h_max,
    input  logic [10:0] wall_v_min,
    input  logic [10:0] wall_v_max,
    output logic        hit
);

    // One extra bit so right/bottom edges never wrap.
    logic [11:0] w_right;
    logic [11:0] w_bottom;

    assign w_right  = {1'b0, left} + {1'b0, length};
    assign w_bottom = {1'b0, top}  + {1'b0, length};

    assign hit = (left <= wall_h_max) &&
                 (w_right >= {1'b0, wall_h_min}) &&
                 (top <= wall_v_max) &&
                 (w_bottom >= {1'b0, wall_v_min});

endmodule

// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
// Moves a square sprite once per video frame from level-sensitive direction
// buttons, clamps it to the screen and refuses any axis move that would make
// it touch the obstacle rectangle. X is resolved first, then Y using the
// already committed X.
// Ports:
//   pixel_clk, rst          : clock, asynchronous active-high reset
//   hcounter, vcounter      : VGA raster counters (frame tick source)
//   up/down/left/right      : direction buttons, level
//   wall_h_min..wall_v_max  : obstacle rectangle, inclusive bounds
//   pos_x, pos_y            : committed square position
//   blocked_x, blocked_y    : axis move rejected in the last update
//   collision               : blocked_x | blocked_y of the last update
//   update_done             : one-cycle pulse at the end of each update
//   LED                     : sticky collision indicator
// -----------------------------------------------------------------------------
module player_motion_ctrl
    import vga_pkg::*;
#(
    parameter int START_X = 100,
    parameter int START_Y = 100,
    parameter int STEP    = STEP_DEF,
    parameter int SQ_LEN  = SQ_LEN_DEF,
    parameter int TICK_V  = TICK_V_DEF,
    parameter int TICK_H  = TICK_H_DEF
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [10:0] hcounter,
    input  logic [10:0] vcounter,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic [10:0] wall_h_min,
    input  logic [10:0] wall_h_max,
    input  logic [10:0] wall_v_min,
    input  logic [10:0] wall_v_max,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic        blocked_x,
    output logic        blocked_y,
    output logic        collision,
    output logic        update_done,
    output logic        LED
);

    localparam logic [10:0]        MAX_X  = 11'(SCREEN_W - SQ_LEN);
    localparam logic [10:0]        MAX_Y  = 11'(SCREEN_H - SQ_LEN);
    localparam logic signed [12:0] STEP_S = 13'(STEP);
    localparam logic signed [12:0] ZERO_S = 13'sd0;

    // Saturating add of a signed step to an unsigned coordinate; a negative
    // result pins to 0 so a left/up move near the edge never wraps to 2047.
    function automatic logic [10:0] sat_axis(
        input logic [10:0]        pos,
        input logic signed [12:0] vel,
        input logic [10:0]        hi
    );
        logic signed [12:0] sum;
        sum = $signed({2'b00, pos}) + vel;
        if (sum < ZERO_S)
            return 11'd0;
        else if (sum > $signed({2'b00, hi}))
            return hi;
        else
            return sum[10:0];
    endfunction

    motion_state_t      r_state;
    logic               r_cond;
    logic               r_cond_d;
    logic signed [12:0] r_vx;
    logic signed [12:0] r_vy;
    logic [10:0]        r_pos_x;
    logic [10:0]        r_pos_y;
    logic               r_blocked_x;
    logic               r_blocked_y;
    logic               r_collision;
    logic               r_update_done;
    logic               r_led;

    logic        w_tick;
    logic [10:0] w_cand_x;
    logic [10:0] w_cand_y;
    logic [10:0] w_ov_left;
    logic [10:0] w_ov_top;
    logic        w_hit;
    logic        w_blk_x;
    logic        w_blk_y;

    assign w_tick   = r_cond & ~r_cond_d;
    assign w_cand_x = sat_axis(r_pos_x, r_vx, MAX_X);
    assign w_cand_y = sat_axis(r_pos_y, r_vy, MAX_Y);

    // The single overlap checker is shared: MOVE_X tests (cand_x, pos_y),
    // MOVE_Y tests (pos_x, cand_y) where pos_x is already the committed value.
    assign w_ov_left = (r_state == MOVE_Y) ? r_pos_x  : w_cand_x;
    assign w_ov_top  = (r_state == MOVE_Y) ? w_cand_y : r_pos_y;

    rect_overlap u_overlap (
        .left       (w_ov_left),
        .top        (w_ov_top),
        .length     (11'(SQ_LEN)),
        .wall_h_min (wall_h_min),
        .wall_h_max (wall_h_max),
        .wall_v_min (wall_v_min),
        .wall_v_max (wall_v_max),
        .hit        (w_hit)
    );

    assign w_blk_x = (r_vx != ZERO_S) && w_hit;
    assign w_blk_y = (r_vy != ZERO_S) && w_hit;

    // Per-frame velocity captured in LATCH; pure data, no reset needed since
    // it is always rewritten before MOVE_X/MOVE_Y consume it.
    always_ff @(posedge pixel_clk) begin
        if (r_state == LATCH) begin
            unique case ({left, right})
                2'b10:   r_vx <= -STEP_S;
                2'b01:   r_vx <= STEP_S;
                default: r_vx <= ZERO_S;
            endcase
            unique case ({up, down})
                2'b10:   r_vy <= -STEP_S;
                2'b01:   r_vy <= STEP_S;
                default: r_vy <= ZERO_S;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cond        <= 1'b0;
            r_cond_d      <= 1'b0;
            r_pos_x       <= 11'(START_X);
            r_pos_y       <= 11'(START_Y);
            r_blocked_x   <= 1'b0;
            r_blocked_y   <= 1'b0;
            r_collision   <= 1'b0;
            r_update_done <= 1'b0;
            r_led         <= 1'b0;
        end else begin
            // Registered tick condition plus delayed copy for edge detection.
            r_cond        <= (vcounter == 11'(TICK_V)) && (hcounter == 11'(TICK_H));
            r_cond_d      <= r_cond;
            r_update_done <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_tick)
                        r_state <= LATCH;
                end
                LATCH: begin
                    r_state <= MOVE_X;
                end
                MOVE_X: begin
                    r_blocked_x <= w_blk_x;
                    if (!w_blk_x)
                        r_pos_x <= w_cand_x;
                    r_state <= MOVE_Y;
                end
                MOVE_Y: begin
                    r_blocked_y <= w_blk_y;
                    if (!w_blk_y)
                        r_pos_y <= w_cand_y;
                    // Loaded here so both are visible during the DONE cycle.
                    r_update_done <= 1'b1;
                    r_collision   <= r_blocked_x | w_blk_y;
                    if (r_blocked_x | w_blk_y)
                        r_led <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign blocked_x   = r_blocked_x;
    assign blocked_y   = r_blocked_y;
    assign collision   = r_collision;
    assign update_done = r_update_done;
    assign LED         = r_led;

endmodule

// File: tb/tb_player_motion_ctrl.sv
module tb_player_motion_ctrl;

    logic        pixel_clk = 1'b0;
    logic        rst;
    logic [10:0] hcounter;
    logic [10:0] vcounter;
    logic [10:0] wall_h_min, wall_h_max, wall_v_min, wall_v_max;
    logic [3:0]  btn [3];   // {up, down, left, right}

    logic [10:0] o_px [3];
    logic [10:0] o_py [3];
    logic        o_bx [3];
    logic        o_by [3];
    logic        o_col [3];
    logic        o_ud [3];
    logic        o_led [3];

    always #5 pixel_clk = ~pixel_clk;

    player_motion_ctrl #(.START_X(100), .START_Y(100)) dut0 (
        .pixel_clk(pixel_clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
        .up(btn[0][3]), .down(btn[0][2]), .left(btn[0][1]), .right(btn[0][0]),
        .wall_h_min(wall_h_min), .wall_h_max(wall_h_max),
        .wall_v_min(wall_v_min), .wall_v_max(wall_v_max),
        .pos_x(o_px[0]), .pos_y(o_py[0]), .blocked_x(o_bx[0]), .blocked_y(o_by[0]),
        .collision(o_col[0]), .update_done(o_ud[0]), .LED(o_led[0]));

    player_motion_ctrl #(.START_X(278), .START_Y(230)) dut1 (
        .pixel_clk(pixel_clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
        .up(btn[1][3]), .down(btn[1][2]), .left(btn[1][1]), .right(btn[1][0]),
        .wall_h_min(wall_h_min), .wall_h_max(wall_h_max),
        .wall_v_min(wall_v_min), .wall_v_max(wall_v_max),
        .pos_x(o_px[1]), .pos_y(o_py[1]), .blocked_x(o_bx[1]), .blocked_y(o_by[1]),
        .collision(o_col[1]), .update_done(o_ud[1]), .LED(o_led[1]));

    player_motion_ctrl #(.START_X(1), .START_Y(100)) dut2 (
        .pixel_clk(pixel_clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
        .up(btn[2][3]), .down(btn[2][2]), .left(btn[2][1]), .right(btn[2][0]),
        .wall_h_min(wall_h_min), .wall_h_max(wall_h_max),
        .wall_v_min(wall_v_min), .wall_v_max(wall_v_max),
        .pos_x(o_px[2]), .pos_y(o_py[2]), .blocked_x(o_bx[2]), .blocked_y(o_by[2]),
        .collision(o_col[2]), .update_done(o_ud[2]), .LED(o_led[2]));

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance
    int sx [3] = '{100, 278, 1};
    int sy [3] = '{100, 230, 100};
    int mx [3];
    int my [3];
    int mbx [3];
    int mby [3];
    int mcol [3];
    int mled [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit overlaps(input int l, input int t);
        return (l <= int'(wall_h_max)) && (l + 20 >= int'(wall_h_min)) &&
               (t <= int'(wall_v_max)) && (t + 20 >= int'(wall_v_min));
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mx[i] = sx[i]; my[i] = sy[i];
            mbx[i] = 0; mby[i] = 0; mcol[i] = 0; mled[i] = 0;
        end
    endtask

    // One whole update per instance, straight from the motion rules.
    task automatic model_frame();
        for (int i = 0; i < 3; i++) begin
            int vx, vy, cx, cy;
            vx = (btn[i][1] && !btn[i][0]) ? -2 : (btn[i][0] && !btn[i][1]) ? 2 : 0;
            vy = (btn[i][3] && !btn[i][2]) ? -2 : (btn[i][2] && !btn[i][3]) ? 2 : 0;
            cx = clampi(mx[i] + vx, 620);
            if (vx != 0 && overlaps(cx, my[i])) mbx[i] = 1;
            else begin mx[i] = cx; mbx[i] = 0; end
            cy = clampi(my[i] + vy, 460);
            if (vy != 0 && overlaps(mx[i], cy)) mby[i] = 1;
            else begin my[i] = cy; mby[i] = 0; end
            mcol[i] = mbx[i] | mby[i];
            if (mcol[i] != 0) mled[i] = 1;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_px%0d", tag, i), 32'(o_px[i]), 32'(mx[i]));
            chk($sformatf("%s_py%0d", tag, i), 32'(o_py[i]), 32'(my[i]));
            chk($sformatf("%s_col%0d", tag, i), 32'(o_col[i]), 32'(mcol[i]));
            chk($sformatf("%s_led%0d", tag, i), 32'(o_led[i]), 32'(mled[i]));
        end
    endtask

    // Raise the tick condition for one cycle, then follow the update edge by edge.
    task automatic do_frame(input string tag);
        @(negedge pixel_clk);
        hcounter = 11'd0; vcounter = 11'd481;
        @(negedge pixel_clk);
        vcounter = 11'd0;
        model_frame();
        for (int j = 1; j <= 6; j++) begin
            @(negedge pixel_clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s_ud%0d_e%0d", tag, i, j), 32'(o_ud[i]), 32'(j == 4));
                if (j == 3)
                    chk($sformatf("%s_px%0d_e3", tag, i), 32'(o_px[i]), 32'(mx[i]));
                if (j == 4) begin
                    chk($sformatf("%s_py%0d", tag, i), 32'(o_py[i]), 32'(my[i]));
                    chk($sformatf("%s_bx%0d", tag, i), 32'(o_bx[i]), 32'(mbx[i]));
                    chk($sformatf("%s_by%0d", tag, i), 32'(o_by[i]), 32'(mby[i]));
                    chk($sformatf("%s_col%0d", tag, i), 32'(o_col[i]), 32'(mcol[i]));
                    chk($sformatf("%s_led%0d", tag, i), 32'(o_led[i]), 32'(mled[i]));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        hcounter = 11'd0; vcounter = 11'd0;
        wall_h_min = 11'd300; wall_h_max = 11'd340;
        wall_v_min = 11'd220; wall_v_max = 11'd260;
        for (int i = 0; i < 3; i++) btn[i] = 4'b0000;
        model_reset();
        repeat (3) @(negedge pixel_clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_ud%0d", i), 32'(o_ud[i]), 32'd0);
        check_all("rst");
        rst = 1'b0;
        repeat (3) @(negedge pixel_clk);

        // Free move / block / clamp in parallel across the three instances
        btn[0] = 4'b0001; btn[1] = 4'b0001; btn[2] = 4'b0010;
        for (int f = 0; f < 3; f++) do_frame($sformatf("mv%0d", f));
        chk("free_px", 32'(o_px[0]), 32'd106);
        chk("free_py", 32'(o_py[0]), 32'd100);
        chk("block_px", 32'(o_px[1]), 32'd278);
        chk("block_bx", 32'(o_bx[1]), 32'd1);
        chk("block_led", 32'(o_led[1]), 32'd1);
        chk("clamp_px", 32'(o_px[2]), 32'd0);
        chk("clamp_col", 32'(o_col[2]), 32'd0);

        // Release buttons: LED must stay lit
        for (int i = 0; i < 3; i++) btn[i] = 4'b0000;
        do_frame("rel");
        chk("rel_led", 32'(o_led[1]), 32'd1);
        chk("rel_col", 32'(o_col[1]), 32'd0);

        // Up+down conflict with left
        btn[0] = 4'b1110;
        do_frame("conf");
        chk("conf_px", 32'(o_px[0]), 32'd104);
        chk("conf_py", 32'(o_py[0]), 32'd100);

        // Reset during MOVE_X
        btn[0] = 4'b0001; btn[1] = 4'b0010; btn[2] = 4'b0001;
        @(negedge pixel_clk);
        hcounter = 11'd0; vcounter = 11'd481;
        @(negedge pixel_clk);
        vcounter = 11'd0;
        @(negedge pixel_clk);
        @(posedge pixel_clk);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("mid");
        for (int i = 0; i < 3; i++)
            chk($sformatf("mid_ud%0d", i), 32'(o_ud[i]), 32'd0);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge pixel_clk);
            for (int i = 0; i < 3; i++)
                chk($sformatf("mid_noud%0d_%0d", i, j), 32'(o_ud[i]), 32'd0);
        end
        check_all("mid_hold");
        do_frame("post");

        // Randomized frames against the model
        for (int f = 0; f < 25; f++) begin
            int hm, vm;
            hm = int'($urandom_range(0, 600));
            vm = int'($urandom_range(0, 440));
            wall_h_min = 11'(hm); wall_h_max = 11'(hm + int'($urandom_range(0, 80)));
            wall_v_min = 11'(vm); wall_v_max = 11'(vm + int'($urandom_range(0, 60)));
            for (int i = 0; i < 3; i++) btn[i] = 4'($urandom_range(0, 15));
            do_frame($sformatf("rnd%0d", f));
            // Change walls outside MOVE_X/MOVE_Y; must not matter
            wall_h_min = 11'd0; wall_h_max = 11'd639;
            wall_v_min = 11'd0; wall_v_max = 11'd479;
            @(negedge pixel_clk);
            check_all($sformatf("rnd%0d_idle", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
